mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Control FSM that sequences the MIPS datapath stages (instruction fetch, decode, execute, memory access, write back) as a multi-cycle processor. It decodes the fetched opcode/funct and drives every datapath select and enable each cycle. Memory accesses stall on a ready handshake. A retired-instruction counter and a sticky illegal-opcode flag are also maintained.

## Interface
- `CNT_W`, 32, width of retired-instruction counter
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `opcode`  in  6  instruction[31:26], valid from DECODE onward (IR output)
- `funct`  in  6  instruction[5:0]
- `zero`  in  1  ALU zero flag from execute stage
- `mem_ready`  in  1  memory completes current read/write this cycle
- `pc_write`  out  1  load PC
- `pc_src`  out  2  0 = ALU result (PC+4), 1 = ALUOut (branch target), 2 = jump target
- `iord`  out  1  0 = memory address from PC, 1 = from ALUOut
- `mem_read`, `mem_write`  out  1 each  memory strobes, held until `mem_ready`
- `ir_write`  out  1  latch instruction register
- `reg_dst`  out  1  1 = rd, 0 = rt
- `mem_to_reg`  out  1  1 = write-back from memory data
- `reg_write`  out  1  register file write enable
- `alu_src_a`  out  1  0 = PC, 1 = register A
- `alu_src_b`  out  2  0 = B, 1 = constant 4, 2 = sign-extended imm, 3 = imm<<2
- `alu_op`  out  4  0 add, 1 sub, 2 and, 3 or, 4 slt
- `illegal`  out  1  sticky, set on unsupported opcode/funct
- `retired`  out  CNT_W  count of completed instructions

## Operation
- States: IDLE, FETCH, DECODE, EX_R, EX_MEMADDR, EX_IMM, EX_BEQ, EX_J, MEM_LW, MEM_SW, WB_R, WB_LW, WB_IMM.
- IDLE: all outputs 0; next FETCH.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=1, alu_op=add, pc_src=0; ir_write and pc_write=1 only in the cycle `mem_ready`=1, then DECODE; else stay.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=add (branch target to ALUOut). Dispatch: 0x00 -> EX_R; 0x23/0x2B -> EX_MEMADDR; 0x08 -> EX_IMM; 0x04 -> EX_BEQ; 0x02 -> EX_J; else set `illegal`, -> FETCH.
- EX_R: alu_src_a=1, alu_src_b=0, alu_op from funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt); unknown funct sets `illegal`, -> FETCH, no write. Else -> WB_R.
- EX_MEMADDR: alu_src_a=1, alu_src_b=2, add; -> MEM_LW (0x23) or MEM_SW (0x2B).
- EX_IMM: as EX_MEMADDR; -> WB_IMM.
- EX_BEQ: alu_src_a=1, alu_src_b=0, sub, pc_src=1, pc_write=`zero`; retire; -> FETCH.
- EX_J: pc_src=2, pc_write=1; retire; -> FETCH.
- MEM_LW: iord=1, mem_read=1; on `mem_ready` -> WB_LW.
- MEM_SW: iord=1, mem_write=1; on `mem_ready` retire, -> FETCH.
- WB_R: reg_dst=1, reg_write=1; WB_LW: reg_dst=0, mem_to_reg=1, reg_write=1; WB_IMM: reg_dst=0, reg_write=1. Each retires, -> FETCH.
- Unlisted outputs are 0 in every state.
- `retired` increments by 1 on the retiring cycle, wraps modulo 2^CNT_W. Illegal instructions do not retire.

## Timing
- Reset: state IDLE, `retired`=0, `illegal`=0, all control outputs 0 (asynchronous, immediate).
- Outputs are Moore-decoded from state, except FETCH ir_write/pc_write (gated by `mem_ready`), EX_BEQ pc_write (by `zero`), EX_R/DECODE dispatch (by opcode/funct).
- Zero-wait latency (cycles from FETCH entry to next FETCH): R-type 4, addi 4, lw 5, sw 4, beq 3, j 3, illegal 2. Each `mem_ready`-low cycle adds one.
- `mem_read`/`mem_write` stay asserted and address select stable while waiting; no timeout.
- Reset mid-instruction: abandon immediately, no partial write-back, counter cleared.

## Structure
- Package `mips_ctrl_pkg`: state enum, opcode and funct constants, alu_op encoding, pc_src/alu_src_b encodings.
- Sub-module `alu_decoder`: combinational funct -> {alu_op, valid}.

## Test plan
- Reset then `add` (op 0x00, funct 0x20), mem_ready=1 -> states IDLE,FETCH,DECODE,EX_R,WB_R; reg_write=1, reg_dst=1 in WB_R; `retired`=1.
- `lw` (0x23) with mem_ready low 2 cycles in MEM_LW -> mem_read, iord=1 held 3 cycles; WB_LW has mem_to_reg=1; total 7 cycles.
- `beq` (0x04) with zero=1 then zero=0 -> pc_write=1, pc_src=1 first; pc_write=0 second; both retire.
- Opcode 0x3F -> `illegal`=1 after DECODE, back to FETCH, `retired` unchanged; flag persists until reset.
- CNT_W=4, 16 `j` instructions -> `retired` wraps to 0.
- Assert `rst` during MEM_SW -> mem_write drops immediately, state IDLE, counter 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states,
// opcode/funct constants and the datapath select encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EX_R,
        S_EX_MEMADDR,
        S_EX_IMM,
        S_EX_BEQ,
        S_EX_J,
        S_MEM_LW,
        S_MEM_SW,
        S_WB_R,
        S_WB_LW,
        S_WB_IMM
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        SRCB_REG   = 2'd0,
        SRCB_FOUR  = 2'd1,
        SRCB_IMM   = 2'd2,
        SRCB_SHIMM = 2'd3
    } alu_src_b_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU operation; valid is low for unsupported funct codes.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       valid
);

    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back,
// counts retired instructions and flags unsupported opcodes or funct codes.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_e     state;
    state_e     next_state;
    logic       retire;
    logic       set_illegal;
    logic [3:0] dec_op;
    logic       dec_valid;

    alu_decoder u_alu_decoder (
        .funct  (funct),
        .alu_op (dec_op),
        .valid  (dec_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (retire)
                retired <= retired + CNT_W'(1);
            if (set_illegal)
                illegal <= 1'b1;
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears them
    // in the same instant; only the handshake/flag gated terms look at inputs.
    always_comb begin
        pc_write    = 1'b0;
        pc_src      = PC_SEQ;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        alu_op      = ALU_ADD;
        next_state  = state;
        retire      = 1'b0;
        set_illegal = 1'b0;

        case (state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_SHIMM;
                case (opcode)
                    OP_RTYPE:     next_state = S_EX_R;
                    OP_LW, OP_SW: next_state = S_EX_MEMADDR;
                    OP_ADDI:      next_state = S_EX_IMM;
                    OP_BEQ:       next_state = S_EX_BEQ;
                    OP_J:         next_state = S_EX_J;
                    default: begin
                        set_illegal = 1'b1;
                        next_state  = S_FETCH;
                    end
                endcase
            end
            S_EX_R: begin
                alu_src_a = 1'b1;
                alu_op    = dec_op;
                if (dec_valid) begin
                    next_state = S_WB_R;
                end else begin
                    set_illegal = 1'b1;
                    next_state  = S_FETCH;
                end
            end
            S_EX_MEMADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                next_state = (opcode == OP_LW) ? S_MEM_LW : S_MEM_SW;
            end
            S_EX_IMM: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                next_state = S_WB_IMM;
            end
            S_EX_BEQ: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_src     = PC_BRANCH;
                pc_write   = zero;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_EX_J: begin
                pc_src     = PC_JUMP;
                pc_write   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_LW: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready)
                    next_state = S_WB_LW;
            end
            S_MEM_SW: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_WB_R: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_WB_LW: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_WB_IMM: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule
